// File: rtl/sram_arbiter.sv
// Two-requester arbiter for an asynchronous SRAM using IDLE/SETUP/ACCESS/HOLD strobe sequencing.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; the default is fixed priority to requester 0.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [18:0] addr0,
  input  logic [18:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic [18:0] ADR,
  output logic [15:0] DAT_O,
  input  logic [15:0] DAT_I,
  output logic        DAT_OE,
  output logic        RAMOE,
  output logic        RAMWE,
  output logic        RAMCS
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_e;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [18:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        grant_sel;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // ptr_q names the requester that wins the next tie
  always_comb begin
    grant_sel = (req0 && req1) ? ptr_q : ~req0;
    ptr_d     = ptr_q;
    if (state_q == IDLE && (req0 || req1)) ptr_d = ~grant_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`else
  assign grant_sel = ~req0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = grant_sel;
          we_d    = grant_sel ? we1    : we0;
          addr_d  = grant_sel ? addr1  : addr0;
          wdata_d = grant_sel ? wdata1 : wdata0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = HOLD;
          if (!we_q) rdata_d = DAT_I;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    RAMCS  = 1'b1;
    RAMOE  = 1'b1;
    RAMWE  = 1'b1;
    DAT_OE = 1'b0;
    ADR    = '0;
    DAT_O  = '0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    unique case (state_q)
      SETUP, ACCESS: begin
        RAMCS = 1'b0;
        ADR   = addr_q;
        if (we_q) begin
          DAT_OE = 1'b1;
          DAT_O  = wdata_q;
          RAMWE  = (state_q != ACCESS);
        end else begin
          RAMOE = 1'b0;
        end
      end
      HOLD: begin
        RAMCS  = 1'b0;
        ADR    = addr_q;
        DAT_OE = we_q;
        DAT_O  = we_q ? wdata_q : '0;
        ack0   = ~gnt_q;
        ack1   = gnt_q;
      end
      default: ;
    endcase
  end

  assign rdata = rdata_q;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, 2, SRAM access-strobe length in clk cycles (legal 1-15).
REQ-002 SHALL have port: clk  input  1  100 MHz system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports: req0, req1  input  1 each  access request from requester 0 / 1.
REQ-005 SHALL have ports: we0, we1  input  1 each  1 = write, 0 = read.
REQ-006 SHALL have ports: addr0, addr1  input  19 each  word address.
REQ-007 SHALL have ports: wdata0, wdata1  input  16 each  write data.
REQ-008 SHALL have ports: ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have port: rdata  output  16  read data, shared by both requesters, valid while the matching ack is high.
REQ-010 SHALL have ports: ADR  output  19; DAT_O  output  16; DAT_I  input  16; DAT_OE  output  1 (drive enable for the external DAT tristate); RAMOE, RAMWE, RAMCS  output  1 each, active-low.

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, ACCESS, HOLD.
REQ-012 In IDLE with any req high, SHALL grant one requester, latch its we/addr/wdata, and go to SETUP next cycle; with no req, SHALL stay in IDLE.
REQ-013 SETUP (1 cycle): SHALL assert RAMCS=0, drive ADR; for a read, RAMOE=0; for a write, DAT_OE=1 and DAT_O=wdata.
REQ-014 ACCESS (WAIT_CYCLES cycles, counted by a 4-bit counter): SHALL hold SETUP outputs; for a write, SHALL also assert RAMWE=0.
REQ-015 On the last ACCESS cycle of a read, SHALL capture DAT_I into rdata.
REQ-016 HOLD (1 cycle): SHALL set RAMWE=1 and RAMOE=1, keep RAMCS=0, ADR and DAT_OE, pulse ack of the granted requester, then return to IDLE.
REQ-017 ack SHALL occur exactly WAIT_CYCLES+2 cycles after the edge on which the request was granted; the other ack SHALL stay 0.
REQ-018 A requester SHALL hold req until its ack; deasserting req mid-transaction SHALL NOT abort it.
REQ-019 A requester that holds req through its ack SHALL be regranted no earlier than the IDLE cycle after HOLD, giving one idle bus cycle between transactions.
REQ-020 RAMWE and RAMOE SHALL never both be 0; DAT_OE SHALL be 0 whenever RAMOE=0.
REQ-021 Outside a transaction: RAMCS=1, RAMOE=1, RAMWE=1, DAT_OE=0, ADR=0, DAT_O=0.
REQ-022 rdata SHALL hold its last value until the next read capture; writes SHALL NOT modify it.

Reset
REQ-023 On rst=1 at a clock edge, SHALL enter IDLE; RAMCS/RAMOE/RAMWE=1, DAT_OE=0, ADR=0, DAT_O=0, rdata=0, ack0=ack1=0, priority pointer=requester 0.
REQ-024 A reset during any state SHALL abort the transaction with no ack and release the bus on the same edge.

Configuration
REQ-025 Macro SRAM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, SHALL grant the requester not served most recently; the pointer SHALL update on each grant.
REQ-026 Macro undefined: SHALL use fixed priority, requester 0 always winning ties; the pointer logic SHALL be absent.

Verification
REQ-027 Single read: req0, we0=0, addr0=0x12345, DAT_I=0xBEEF, WAIT_CYCLES=2 -> ADR=0x12345, RAMOE=0 for 3 cycles, ack0 4 cycles after grant, rdata=0xBEEF.
REQ-028 Single write: req1, we1=1, addr1=0x7FFFF, wdata1=0xA5A5 -> DAT_OE=1, DAT_O=0xA5A5, RAMWE=0 for exactly 2 cycles inside RAMCS=0, ack1 pulse, rdata unchanged.
REQ-029 Simultaneous req0+req1 held for 4 transactions -> with macro: grants 0,1,0,1; without: 0,0,0,0 and ack1 never.
REQ-030 rst pulsed during ACCESS of a write -> next edge: RAMWE=1, RAMCS=1, DAT_OE=0, no ack; a fresh request then completes normally.
REQ-031 WAIT_CYCLES=1 and WAIT_CYCLES=15 back-to-back reads on req0 -> ack spacing 4 and 18 cycles respectively; RAMWE/RAMOE exclusivity checked by assertion every cycle.
